// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clock, with round keys expanded
// forward once per new key and cached for back-to-back blocks that reuse it.
module inv_cipher #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:127]      in,
    input  logic [0:32*Nk-1]  key,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [0:127]      out,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [3:0] LAST = 4'(Nr);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ARK, S_ROUND, S_DONE} fsm_t;

    // Table entry for byte x sits at bit 8*(255-x)+7 because entry 0 is the MSB.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        inv_sbox = INV_SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = prev[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = w3           ^ n2;
        expand_key = {n0, n1, n2, n3};
    endfunction

    // Row r of the state is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        inv_shift_rows = o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int b = 0; b < 16; b++) begin
            o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
        end
        inv_sub_bytes = o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                       m9[0] ^ me[1] ^ mb[2] ^ md[3],
                       md[0] ^ m9[1] ^ me[2] ^ mb[3],
                       mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        inv_mix_columns = {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                           inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    logic [127:0] in_w, key_w;
    fsm_t         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         kv_q, kv_d;
    logic [127:0] out_q, out_d;
    logic [127:0] aes_q, aes_d;
    logic [127:0] last_key_q, last_key_d;
    logic [127:0] rk_q [0:Nr];
    logic         rk_we;
    logic [3:0]   rk_wa;
    logic [127:0] rk_wd;
    logic [127:0] key_next, round_t;

    assign in_w      = in;
    assign key_w     = key;
    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign out       = out_q;

    assign key_next = expand_key(rk_q[cnt_q - 4'd1], rcon(cnt_q));
    assign round_t  = inv_sub_bytes(inv_shift_rows(aes_q)) ^ rk_q[LAST - cnt_q];

    always_comb begin
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        kv_d       = kv_q;
        out_d      = out_q;
        aes_d      = aes_q;
        last_key_d = last_key_q;
        rk_we      = 1'b0;
        rk_wa      = cnt_q;
        rk_wd      = key_next;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    aes_d      = in_w;
                    last_key_d = key_w;
                    rk_we      = 1'b1;
                    rk_wa      = 4'd0;
                    rk_wd      = key_w;
                    cnt_d      = 4'd1;
                    if (kv_q && key_w == last_key_q) begin
                        fsm_d = S_ARK;
                    end else begin
                        kv_d  = 1'b0;
                        fsm_d = S_KEXP;
                    end
                end
            end
            S_KEXP: begin
                rk_we = 1'b1;
                if (cnt_q == LAST) begin
                    kv_d  = 1'b1;
                    fsm_d = S_ARK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ARK: begin
                aes_d = aes_q ^ rk_q[LAST];
                cnt_d = 4'd1;
                fsm_d = S_ROUND;
            end
            S_ROUND: begin
                // The final round has no InvMixColumns and goes straight to the output.
                if (cnt_q == LAST) begin
                    out_d = round_t;
                    fsm_d = S_DONE;
                end else begin
                    aes_d = inv_mix_columns(round_t);
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
            cnt_q <= 4'd0;
            kv_q  <= 1'b0;
            out_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            kv_q  <= kv_d;
            out_q <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        aes_q      <= aes_d;
        last_key_q <= last_key_d;
        if (rk_we) begin
            rk_q[rk_wa] <= rk_wd;
        end
    end

endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher using FIPS-197 vectors, checking results and latencies.
`timescale 1ns/1ps
module tb_inv_cipher;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'hc6a13b37878f5b826f4f8162a1c8d879;
    localparam logic [127:0] P2 = 128'h0;
    localparam logic [127:0] C3 = 128'h0a940bb5416ef045f1c39458c653ea5a;
    localparam logic [127:0] P3 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C4 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P4 = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:127] tb_in, tb_key, tb_out;
    logic         in_valid, in_ready, out_valid, out_ready;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    inv_cipher dut (
        .clk(clk), .rst_n(rst_n), .in(tb_in), .key(tb_key), .in_valid(in_valid),
        .in_ready(in_ready), .out(tb_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Accepts one block and returns the edge count from accept to out_valid (40 = timed out).
    task automatic run_block(input logic [127:0] ct, input logic [127:0] k, input bit scramble,
                             output logic [127:0] res, output int lat);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        tb_in = ct; tb_key = k; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (scramble) begin
                tb_in  = {$urandom, $urandom, $urandom, $urandom};
                tb_key = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            lat++;
        end
        res = tb_out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; tb_in = '0; tb_key = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (tb_out !== 128'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", tb_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_fips_c1;
        logic [127:0] res; int lat;
        out_ready = 1'b1;
        run_block(C1, K1, 1'b0, res, lat);
        n_checks++; if (res !== P1) begin n_fail++; $display("FAIL c1_out: got %h want %h", res, P1); end
        n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL c1_latency: got %0d want 21", lat); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL c1_done_one_cycle: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL c1_ready_after: got %b want 1", in_ready); end
        n_checks++; if (tb_out !== P1) begin n_fail++; $display("FAIL c1_out_held: got %h want %h", tb_out, P1); end
    endtask

    task automatic test_key_reuse;
        logic [127:0] res; int lat;
        run_block(C2, K1, 1'b0, res, lat);
        n_checks++; if (res !== P2) begin n_fail++; $display("FAIL reuse1_out: got %h want %h", res, P2); end
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL reuse1_latency: got %0d want 11", lat); end
        @(posedge clk); #1;
        run_block(C3, K1, 1'b0, res, lat);
        n_checks++; if (res !== P3) begin n_fail++; $display("FAIL reuse2_out: got %h want %h", res, P3); end
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL reuse2_latency: got %0d want 11", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [127:0] res; int lat;
        out_ready = 1'b0;
        run_block(C1, K1, 1'b0, res, lat);
        n_checks++; if (res !== P1) begin n_fail++; $display("FAIL bp_out: got %h want %h", res, P1); end
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL bp_latency: got %0d want 11", lat); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; tb_in = 128'hdeadbeef; tb_key = 128'hcafef00d;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold%0d: got %b want 1", i, out_valid); end
            n_checks++; if (tb_out !== P1) begin n_fail++; $display("FAIL bp_out_hold%0d: got %h want %h", i, tb_out, P1); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_busy%0d: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_junk_ignored%0d: got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_key_change;
        logic [127:0] res; int lat;
        run_block(C4, K4, 1'b0, res, lat);
        n_checks++; if (res !== P4) begin n_fail++; $display("FAIL kchg_out: got %h want %h", res, P4); end
        n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL kchg_latency: got %0d want 21", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_round;
        logic [127:0] res; int lat;
        tb_in = C4; tb_key = K4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (tb_out !== 128'h0) begin n_fail++; $display("FAIL rst_mid_out: got %h want 0", tb_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_hold_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        run_block(C4, K4, 1'b0, res, lat);
        n_checks++; if (res !== P4) begin n_fail++; $display("FAIL rst_resubmit_out: got %h want %h", res, P4); end
        n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL rst_resubmit_latency: got %0d want 21", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_input_hold;
        logic [127:0] res; int lat;
        run_block(C1, K1, 1'b1, res, lat);
        n_checks++; if (res !== P1) begin n_fail++; $display("FAIL hold_out: got %h want %h", res, P1); end
        n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL hold_latency: got %0d want 21", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_key_reuse();
        test_backpressure();
        test_key_change();
        test_reset_mid_round();
        test_input_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
